// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_pkg
//  Brief    : Shared constants for the sequential signed divider: default
//             operand widths and the controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package seq_div_pkg;

   // Default operand widths (dividend/quotient, divisor/remainder)
   localparam int DIVIDEND_W_DEF = 8;
   localparam int DIVISOR_W_DEF  = 4;

   // Controller state enumeration
   localparam int         STATE_W = 2;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   typedef logic [STATE_W-1:0] state_t;

endpackage : seq_div_pkg
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_step
//  Brief    : One restoring-division iteration on unsigned magnitudes:
//             shift partial remainder, bring in next dividend bit, trial
//             subtract divisor magnitude, keep or restore, emit quotient bit.
//  Revision : 1.0  initial release
// ============================================================================
module seq_div_step
   import seq_div_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W:0]   rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] dvsr_mag,
   output logic [DIVISOR_W:0]   rem_out,
   output logic                 q_bit
);

   logic [DIVISOR_W:0]   shifted;
   logic [DIVISOR_W+1:0] diff;

   // The partial remainder is always below the divisor magnitude
   // (at most 2^(DIVISOR_W-1)), so its MSB is zero and drops out of the shift.
   logic unused_rem_msb;
   assign unused_rem_msb = rem_in[DIVISOR_W];

   // Shift, trial-subtract, and select kept or restored remainder
   always_comb begin
      shifted = {rem_in[DIVISOR_W-1:0], bit_in};
      diff    = {1'b0, shifted} - {2'b00, dvsr_mag};
      q_bit   = ~diff[DIVISOR_W+1];
      rem_out = q_bit ? diff[DIVISOR_W:0] : shifted;
   end

endmodule : seq_div_step
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Brief    : Sequential signed divider, truncating toward zero. One
//             restoring step per clock on operand magnitudes, sign fix-up on
//             the final step. Divide-by-zero and most-negative / -1 overflow
//             are flagged.
//  Config   : SEQ_DIV_REMAINDER_EN - when defined the signed remainder is
//             produced; otherwise remainder_o is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module seq_div
   import seq_div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend_i,
   input  logic [DIVISOR_W-1:0]  divisor_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DIVIDEND_W-1:0] quotient_o,
   output logic [DIVISOR_W-1:0]  remainder_o,
   output logic                  dbz_o,
   output logic                  ovf_o
);

   localparam int                 CNT_W    = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DIVIDEND_W - 1);
   localparam logic [DIVIDEND_W-1:0] DVD_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [DIVISOR_W:0]    rem;
   logic [DIVIDEND_W-1:0] dvd;        // dividend magnitude, quotient shifts in at LSB
   logic [DIVISOR_W-1:0]  dvsr_mag;
   logic                  neg_q;
   logic                  ovf_pend;

   logic                  dvd_neg;
   logic                  dvsr_neg;
   logic [DIVIDEND_W-1:0] dvd_mag_in;
   logic [DIVISOR_W-1:0]  dvsr_mag_in;
   logic                  dvsr_zero;
   logic                  ovf_in;
   logic                  accept;
   logic                  last_step;

   logic [DIVISOR_W:0]    step_rem;
   logic                  step_q;
   logic [DIVIDEND_W-1:0] step_quot;
   logic [DIVIDEND_W-1:0] quot_signed;

   // Operand magnitudes and special-case detection on the raw inputs
   always_comb begin
      dvd_neg     = dividend_i[DIVIDEND_W-1];
      dvsr_neg    = divisor_i[DIVISOR_W-1];
      dvd_mag_in  = dvd_neg  ? (~dividend_i + DIVIDEND_W'(1)) : dividend_i;
      dvsr_mag_in = dvsr_neg ? (~divisor_i  + DIVISOR_W'(1))  : divisor_i;
      dvsr_zero   = (divisor_i == '0);
      ovf_in      = (dividend_i == DVD_MIN) && (divisor_i == '1);
   end

   assign accept    = (state == S_IDLE) && start;
   assign last_step = (state == S_CALC) && (cnt == LAST_CNT);
   assign busy_o    = (state != S_IDLE);
   assign done_o    = (state == S_DONE);

   seq_div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_in   (rem),
      .bit_in   (dvd[DIVIDEND_W-1]),
      .dvsr_mag (dvsr_mag),
      .rem_out  (step_rem),
      .q_bit    (step_q)
   );

   // Quotient after the current step, sign-corrected for the final load.
   // For most-negative / -1 the magnitude 2^(W-1) wraps to the most-negative
   // code, which is exactly the required saturated quotient.
   always_comb begin
      step_quot   = {dvd[DIVIDEND_W-2:0], step_q};
      quot_signed = neg_q ? (~step_quot + DIVIDEND_W'(1)) : step_quot;
   end

   // Controller, datapath registers and quotient/flag result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         rem        <= '0;
         dvd        <= '0;
         dvsr_mag   <= '0;
         neg_q      <= 1'b0;
         ovf_pend   <= 1'b0;
         quotient_o <= '0;
         dbz_o      <= 1'b0;
         ovf_o      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (dvsr_zero) begin
                     state      <= S_DONE;
                     quotient_o <= '1;
                     dbz_o      <= 1'b1;
                     ovf_o      <= 1'b0;
                  end else begin
                     state    <= S_CALC;
                     cnt      <= '0;
                     rem      <= '0;
                     dvd      <= dvd_mag_in;
                     dvsr_mag <= dvsr_mag_in;
                     neg_q    <= dvd_neg ^ dvsr_neg;
                     ovf_pend <= ovf_in;
                  end
               end
            end
            S_CALC: begin
               rem <= step_rem;
               dvd <= step_quot;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  state      <= S_DONE;
                  quotient_o <= quot_signed;
                  dbz_o      <= 1'b0;
                  ovf_o      <= ovf_pend;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_DIV_REMAINDER_EN
   logic                 neg_r;
   logic [DIVISOR_W-1:0] rem_mag;
   logic [DIVISOR_W-1:0] rem_signed;

   // Remainder takes the dividend's sign; magnitude is below |divisor|
   always_comb begin
      rem_mag    = step_rem[DIVISOR_W-1:0];
      rem_signed = neg_r ? (~rem_mag + DIVISOR_W'(1)) : rem_mag;
   end

   // Remainder sign capture and remainder result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_r       <= 1'b0;
         remainder_o <= '0;
      end else begin
         if (accept) begin
            neg_r <= dvd_neg;
            if (dvsr_zero) begin
               remainder_o <= '0;
            end
         end
         if (last_step) begin
            remainder_o <= rem_signed;
         end
      end
   end
`else
   assign remainder_o = '0;
`endif

endmodule : seq_div
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Brief    : Self-checking bench for seq_div. Stimulus pushes expected
//             results (from integer / and %) into a scoreboard; a monitor
//             pops and compares on every done_o pulse.
//  Config   : SEQ_DIV_REMAINDER_EN selects whether a remainder is expected.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_div;

   localparam int DW = 8;
   localparam int SW = 4;

   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          dbz;
      logic          ovf;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] dividend_i;
   logic [SW-1:0] divisor_i;
   logic          busy_o;
   logic          done_o;
   logic [DW-1:0] quotient_o;
   logic [SW-1:0] remainder_o;
   logic          dbz_o;
   logic          ovf_o;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   seq_div #(
      .DIVIDEND_W (DW),
      .DIVISOR_W  (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .dbz_o       (dbz_o),
      .ovf_o       (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed division truncating toward zero, special cases first
   function automatic exp_t model(input int a, input int b);
      exp_t e;
      int   q;
      int   r;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == 0) begin
         q = -1; r = 0; e.dbz = 1'b1;
      end else if (a == -(1 << (DW - 1)) && b == -1) begin
         q = a; r = 0; e.ovf = 1'b1;
      end else begin
         q = a / b; r = a % b;
      end
`ifndef SEQ_DIV_REMAINDER_EN
      r = 0;
`endif
      e.q = q[DW-1:0];
      e.r = r[SW-1:0];
      return e;
   endfunction

   task automatic chk(input string name, input bit ok, input longint got, input longint req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, got, got, req, req, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (done_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1'b0, 1, 0);
         end else begin
            e = sb.pop_front();
            chk("quotient",  quotient_o  === e.q,   longint'($signed(quotient_o)),  longint'($signed(e.q)));
            chk("remainder", remainder_o === e.r,   longint'($signed(remainder_o)), longint'($signed(e.r)));
            chk("flags", {dbz_o, ovf_o} === {e.dbz, e.ovf}, longint'({dbz_o, ovf_o}), longint'({e.dbz, e.ovf}));
         end
      end
   end

   // Issue one division; checks latency, busy window, post-done idle and hold.
   // With poke set, start is pulsed with junk operands during CALC and DONE.
   task automatic run_op(input int a, input int b, input bit poke);
      exp_t e;
      int   got;
      int   exp_lat;
      bit   busy_ok;
      int   guard;
      guard = 0;
      while (busy_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      e = model(a, b);
      sb.push_back(e);
      start      = 1'b1;
      dividend_i = a[DW-1:0];
      divisor_i  = b[SW-1:0];
      @(posedge clk);
      #1;
      start      = 1'b0;
      dividend_i = DW'($urandom);
      divisor_i  = SW'($urandom);
      exp_lat    = (b == 0) ? 1 : DW + 1;
      got        = 0;
      busy_ok    = 1'b1;
      for (int c = 1; c <= DW + 4 && got == 0; c++) begin
         @(negedge clk);
         if (!busy_o) busy_ok = 1'b0;
         if (done_o) got = c;
         if (poke && c == 3 && got == 0) begin
            start      = 1'b1;
            dividend_i = DW'($urandom);
            divisor_i  = SW'($urandom);
         end
         if (poke && c == 4) start = 1'b0;
      end
      chk("done_latency", got == exp_lat, got, exp_lat);
      chk("busy_window", busy_ok, busy_ok, 1);
      if (poke) begin
         start      = 1'b1;
         dividend_i = DW'($urandom);
         divisor_i  = SW'($urandom | 1);
      end
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", {busy_o, done_o} == 2'b00, longint'({busy_o, done_o}), 0);
      chk("result_hold", {quotient_o, remainder_o, dbz_o, ovf_o} === {e.q, e.r, e.dbz, e.ovf},
          longint'({quotient_o, remainder_o, dbz_o, ovf_o}), longint'({e.q, e.r, e.dbz, e.ovf}));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] ra;
      logic [SW-1:0] rb;
      int            a;
      int            b;
      bit            ok;

      rst        = 1'b0;
      start      = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o} == '0,
          longint'({busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o}), 0);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op( 100,  7, 1'b1);
      run_op(-100,  7, 1'b0);
      run_op( 100, -7, 1'b1);
      run_op(-100, -7, 1'b0);
      run_op(-128, -8, 1'b0);
      run_op(-128, -1, 1'b1);
      run_op(  37,  0, 1'b1);
      run_op( 127, -8, 1'b0);
      run_op(-128,  1, 1'b0);

      // Randomized cases biased toward the boundary operands
      for (int i = 0; i < 40; i++) begin
         ra = DW'($urandom);
         rb = SW'($urandom);
         a  = $signed(ra);
         b  = $signed(rb);
         case ($urandom_range(0, 7))
            0: b = 0;
            1: b = -1;
            2: b = -(1 << (SW - 1));
            3: a = -(1 << (DW - 1));
            default: ;
         endcase
         run_op(a, b, 1'(i % 3 == 0));
      end

      // Reset asserted in the fourth CALC cycle abandons the operation
      @(negedge clk);
      start      = 1'b1;
      dividend_i = 8'd100;
      divisor_i  = 4'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midcalc_reset_outputs", {busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o} == '0,
          longint'({busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      ok  = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (done_o || busy_o) ok = 1'b0;
      end
      chk("no_done_after_reset", ok, ok, 1);
      chk("quotient_after_reset", quotient_o == '0, longint'(quotient_o), 0);

      // Recovery after reset
      run_op(100, 7, 1'b0);
      run_op(-77, 3, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_div
`default_nettype wire

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, meaning signed dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 4, meaning signed divisor and remainder width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as the codebase does: clk, rst.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-007 SHALL have port dividend_i, input, DIVIDEND_W, signed dividend, captured on accepted start.
REQ-008 SHALL have port divisor_i, input, DIVISOR_W, signed divisor, captured on accepted start.
REQ-009 SHALL have port busy_o, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done_o, output, 1, one-cycle pulse marking valid results.
REQ-011 SHALL have port quotient_o, output, DIVIDEND_W, signed quotient.
REQ-012 SHALL have port remainder_o, output, DIVISOR_W, signed remainder.
REQ-013 SHALL have port dbz_o, output, 1, divide-by-zero flag.
REQ-014 SHALL have port ovf_o, output, 1, quotient overflow flag.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE: IDLE->CALC on start with divisor nonzero; IDLE->DONE on start with divisor zero; CALC->DONE after DIVIDEND_W CALC cycles; DONE->IDLE unconditionally.
REQ-016 SHALL, in CALC, perform one restoring-division step per cycle on operand magnitudes: shift partial remainder (DIVISOR_W+1 bits) left by one, bring in the next dividend MSB, subtract the divisor magnitude, and keep the result with quotient bit 1 if non-negative, else restore with quotient bit 0.
REQ-017 SHALL truncate toward zero: quotient negative iff operand signs differ; remainder carries the dividend sign; dividend = quotient*divisor + remainder.
REQ-018 SHALL load quotient_o, remainder_o, dbz_o, ovf_o on the edge entering DONE and hold them until the next entry to DONE.
REQ-019 SHALL assert done_o only in DONE: cycle DIVIDEND_W+1 after the start-accepting edge for nonzero divisor, cycle 1 for a zero divisor.
REQ-020 SHALL ignore start while in CALC or DONE, including start coincident with done_o; operand changes after capture SHALL NOT affect results.
REQ-021 SHALL, on divisor zero, output dbz_o=1, quotient_o=all ones (-1), remainder_o=0, ovf_o=0.
REQ-022 SHALL, on dividend = most-negative value and divisor = -1, output ovf_o=1, quotient_o=most-negative value, remainder_o=0.
REQ-023 SHALL handle divisor = most-negative DIVISOR_W value (magnitude 2^(DIVISOR_W-1)) without error.

Reset
REQ-024 SHALL, while rst is low, force state IDLE, counter 0, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, dbz_o=0, ovf_o=0, regardless of clk.
REQ-025 SHALL abandon any operation in progress when rst is asserted mid-CALC; no done_o pulse follows.

Configuration
REQ-026 SHALL honour macro SEQ_DIV_REMAINDER_EN: defined, remainder computed and sign-corrected per REQ-017; undefined, remainder_o tied to 0 and remainder sign-correction logic omitted, quotient unaffected.

Structure
REQ-027 SHALL place the state enumeration and default width constants in package seq_div_pkg.
REQ-028 SHALL place the single restoring step (shift, subtract, select, quotient bit) in sub-module seq_div_step, instantiated once.

Verification
REQ-029 SHALL check 100 / 7 -> quotient 14, remainder 2, done_o at cycle 9, busy_o high cycles 1..9.
REQ-030 SHALL check sign cases: -100/7 -> -14,-2; 100/-7 -> -14,2; -100/-7 -> 14,-2; -128/-8 -> 16,0.
REQ-031 SHALL check -128 / -1 -> ovf_o=1, quotient -128, remainder 0.
REQ-032 SHALL check 37 / 0 -> dbz_o=1, quotient -1, remainder 0, done_o at cycle 1.
REQ-033 SHALL check start pulsed during CALC and during DONE is ignored, and rst low at cycle 4 of CALC yields all outputs 0 and no done_o.
REQ-034 SHALL rerun 100 / 7 with SEQ_DIV_REMAINDER_EN undefined -> quotient 14, remainder_o 0.
